ctr_gate: RTL and testbench
===========================

Name: ctr_gate

Overview:
- Single-clock, parametrised successor of the reciprocal counter.
- Channel inputs are synchronised into the clk domain and edge-detected.
- Begin, end and event channels are each chosen from N inputs, with optional inversion.
- Counts event edges and reference clocks inside a begin-to-end gate. Adds start/abort control, a timeout, overflow flags and a done handshake; sits between the input front-end and the measurement controller.

Parameters:
CHANNELS, 4, number of asynchronous input channels (>=2)
SIZE, 32, width of event and clock counters
SYNC, 2, synchroniser depth in flops (>=2)
SW, $clog2(CHANNELS), select width (derived, not overridable)

Ports:
clk  in  1  reference clock
rst  in  1  synchronous, active-high reset
inp  in  CHANNELS  asynchronous channel inputs
bsel  in  SW  begin channel select
binv  in  1  begin polarity: 0 rising, 1 falling
esel  in  SW  end channel select
einv  in  1  end polarity
csel  in  SW  counted-event channel select (rising edges only)
start  in  1  pulse: clear counters, arm gate
stop  in  1  pulse: request close at next end edge
abort  in  1  pulse: return to IDLE, counters hold
tmo  in  SIZE  clock-count timeout, 0 = disabled
busy  out  1  high in ARM, RUN or CLOSE
done  out  1  one-cycle pulse on entry to DONE
cte  out  SIZE  event count
ctc  out  SIZE  reference clock count
ovf  out  1  sticky: a counter saturated
tof  out  1  sticky: measurement ended by timeout

Behaviour:
- Reset (sync, rst=1 at posedge): state IDLE; cte=0, ctc=0, ovf=0, tof=0, busy=0, done=0; synchroniser and edge history flops 0.
- Edges:
  - Each channel passes through SYNC flops, then a 1-flop history.
  - Edge pulse = (cur^inv) & !(prev^inv), evaluated per select.
  - Latency from input transition to edge pulse: SYNC+1 clocks.
  - Selects and inversions are sampled every cycle; changing them while busy is undefined.
- States: IDLE, ARM, RUN, CLOSE, DONE.
- IDLE: on start: cte=0, ctc=0, ovf=0, tof=0 -> ARM.
- ARM: on begin edge:
  - ctc=1; cte=1 if an event edge falls in the same cycle, else 0.
  - -> RUN.
- RUN:
  - ctc+1 every cycle; cte+1 on each event edge.
  - stop -> CLOSE; counting continues in that cycle.
- CLOSE: counting continues; on end edge -> DONE, with no increment in that cycle.
  - An end edge coinciding with the stop cycle is ignored; only edges after stop is accepted close the gate.
- Counting window:
  - Begin edge at cycle t0, end edge at t1: ctc = t1-t0.
  - cte = event edges in cycles t0..t1-1.
- Timeout: in RUN or CLOSE, if tmo!=0 and the next ctc would equal tmo -> DONE, tof=1, ctc=tmo.
- Saturation: a counter at all-ones holds and sets ovf; the gate keeps running.
- DONE: done=1 for one cycle, then IDLE; cte/ctc/ovf/tof hold until the next start.
- Priority: rst > abort > start > edges/stop.
  - abort in any state -> IDLE, counters hold, no done.
  - start while busy restarts: clear counters -> ARM.
  - start in the DONE cycle is honoured (-> ARM).
- busy = state in {ARM, RUN, CLOSE}.
- Same channel for begin and end is legal: period measurement with N periods set by stop timing.

Decomposition:
- Package ctr_pkg holds:
  - state enum (IDLE=0, ARM=1, RUN=2, CLOSE=3, DONE=4, 3 bits);
  - localparam for minimum SYNC;
  - saturating-increment function.
- One sub-module, ctr_edge: SYNC-stage synchroniser plus history flop for the CHANNELS-wide bus. Outputs the cur and prev vectors; the top does select, inversion and edge logic.

Test Plan:
- Period: CHANNELS=4; bsel=esel=csel=0; 100-clk square wave on inp[0]; start; stop 250 clks after begin -> done; ctc=300, cte=3, ovf=0, tof=0.
- Inversion/cross-channel: binv=1 on inp[1], einv=0 on inp[2]; falling edge on inp[1] at t0, stop, rising edge on inp[2] at t0+37 -> ctc=37.
- Timeout: tmo=50, no end edge after stop -> done at ctc=50, tof=1.
- Saturation: SIZE=4, gate open 40 clks -> ctc=15, ovf=1, done still issued on the end edge.
- Abort: abort in RUN at ctc=20 -> IDLE, busy=0, no done, ctc holds 20; a following start clears to 0.
- Reset/race: rst asserted in CLOSE -> all outputs 0 next cycle; end edge in the stop cycle ignored, next end edge closes.

Source files
------------

// File: rtl/ctr_pkg.sv
// Shared types and helpers for the ctr_gate gated counter.
package ctr_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ARM   = 3'd1,
    RUN   = 3'd2,
    CLOSE = 3'd3,
    DONE  = 3'd4
  } state_e;

  localparam int MIN_SYNC = 2;
  localparam int MAX_SIZE = 64;

  // Increment v, holding at the w-bit all-ones value.
  function automatic logic [MAX_SIZE-1:0] sat_inc(input logic [MAX_SIZE-1:0] v, input int w);
    logic [MAX_SIZE-1:0] lim;
    lim = (w >= MAX_SIZE) ? '1 : ((MAX_SIZE'(1) << w) - MAX_SIZE'(1));
    return (v >= lim) ? lim : v + MAX_SIZE'(1);
  endfunction

endpackage

// File: rtl/ctr_edge.sv
// Channel synchroniser plus one history flop; edge extraction is left to the consumer.
module ctr_edge
  import ctr_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int SYNC     = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] inp_i,
  output logic [CHANNELS-1:0] cur_o,
  output logic [CHANNELS-1:0] prev_o
);

  localparam int DEPTH = (SYNC < MIN_SYNC) ? MIN_SYNC : SYNC;

  logic [DEPTH-1:0][CHANNELS-1:0] sync_q;
  logic [CHANNELS-1:0]            prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[DEPTH-2:0], inp_i};
      prev_q <= sync_q[DEPTH-1];
    end
  end

  assign cur_o  = sync_q[DEPTH-1];
  assign prev_o = prev_q;

endmodule

// File: rtl/ctr_gate.sv
// Gated event/reference-clock counter: begin edge opens, stop arms close, end edge closes.
module ctr_gate
  import ctr_pkg::*;
#(
  parameter  int CHANNELS = 4,
  parameter  int SIZE     = 32,
  parameter  int SYNC     = 2,
  localparam int SW       = $clog2(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] inp,
  input  logic [SW-1:0]       bsel,
  input  logic                binv,
  input  logic [SW-1:0]       esel,
  input  logic                einv,
  input  logic [SW-1:0]       csel,
  input  logic                start,
  input  logic                stop,
  input  logic                abort,
  input  logic [SIZE-1:0]     tmo,
  output logic                busy,
  output logic                done,
  output logic [SIZE-1:0]     cte,
  output logic [SIZE-1:0]     ctc,
  output logic                ovf,
  output logic                tof
);

  logic [CHANNELS-1:0] cur, prev;
  logic                bedge, eedge, cedge;
  state_e              state_q, state_d;
  logic [SIZE-1:0]     cte_q, cte_d, ctc_q, ctc_d, cte_inc, ctc_inc;
  logic                ovf_q, ovf_d, tof_q, tof_d;
  logic                tmo_hit, counting;

  ctr_edge #(.CHANNELS(CHANNELS), .SYNC(SYNC)) u_edge (
    .clk    (clk),
    .rst    (rst),
    .inp_i  (inp),
    .cur_o  (cur),
    .prev_o (prev)
  );

  assign bedge = (cur[bsel] ^ binv) & ~(prev[bsel] ^ binv);
  assign eedge = (cur[esel] ^ einv) & ~(prev[esel] ^ einv);
  assign cedge = cur[csel] & ~prev[csel];

  assign ctc_inc  = SIZE'(sat_inc(MAX_SIZE'(ctc_q), SIZE));
  assign cte_inc  = SIZE'(sat_inc(MAX_SIZE'(cte_q), SIZE));
  assign tmo_hit  = (tmo != '0) && (ctc_inc == tmo);
  // The closing end-edge cycle itself is outside the window, so it never counts.
  assign counting = (state_q == RUN) || ((state_q == CLOSE) && !eedge);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (abort)      state_d = IDLE;
    else if (start) state_d = ARM;
    else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        ARM:     if (bedge) state_d = RUN;
        RUN:     if (tmo_hit) state_d = DONE;
                 else if (stop) state_d = CLOSE;
        CLOSE:   if (eedge || tmo_hit) state_d = DONE;
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ARM) || (state_q == RUN) || (state_q == CLOSE);
    done = (state_q == DONE);
  end

  always_comb begin
    cte_d = cte_q;
    ctc_d = ctc_q;
    ovf_d = ovf_q;
    tof_d = tof_q;
    if (!abort) begin
      if (start) begin
        cte_d = '0;
        ctc_d = '0;
        ovf_d = 1'b0;
        tof_d = 1'b0;
      end else if ((state_q == ARM) && bedge) begin
        ctc_d = SIZE'(1);
        cte_d = SIZE'(cedge);
      end else if (counting) begin
        ctc_d = tmo_hit ? tmo : ctc_inc;
        tof_d = tof_q | tmo_hit;
        if (cedge) cte_d = cte_inc;
        ovf_d = ovf_q | (&ctc_q) | (cedge & (&cte_q));
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cte_q <= '0;
      ctc_q <= '0;
      ovf_q <= 1'b0;
      tof_q <= 1'b0;
    end else begin
      cte_q <= cte_d;
      ctc_q <= ctc_d;
      ovf_q <= ovf_d;
      tof_q <= tof_d;
    end
  end

  assign cte = cte_q;
  assign ctc = ctc_q;
  assign ovf = ovf_q;
  assign tof = tof_q;

endmodule

// File: tb/tb_ctr_gate.sv
// Randomised bench for ctr_gate; expectations come from an edge-log window model.
module tb_ctr_gate;

  localparam int CH   = 4;
  localparam int SYNC = 2;
  localparam int MAXC = 60000;
  localparam int BIG  = 1 << 30;

  logic        clk, rst;
  logic [3:0]  inp;
  logic [1:0]  bsel, esel, csel;
  logic        binv, einv, start, stop, abort;
  logic [31:0] tmo;
  logic        busy, done, ovf, tof;
  logic [31:0] cte, ctc;
  logic        busy_s, done_s, ovf_s, tof_s;
  logic [3:0]  cte_s, ctc_s;

  int errs = 0, checks = 0, cyc = 0;
  int hp[CH], ph[CH];
  logic [CH-1:0] lvl [0:MAXC];

  ctr_gate #(.CHANNELS(4), .SIZE(32), .SYNC(SYNC)) dut (
    .clk(clk), .rst(rst), .inp(inp), .bsel(bsel), .binv(binv), .esel(esel), .einv(einv),
    .csel(csel), .start(start), .stop(stop), .abort(abort), .tmo(tmo),
    .busy(busy), .done(done), .cte(cte), .ctc(ctc), .ovf(ovf), .tof(tof));

  ctr_gate #(.CHANNELS(4), .SIZE(4), .SYNC(SYNC)) dut_s (
    .clk(clk), .rst(rst), .inp(inp), .bsel(bsel), .binv(binv), .esel(esel), .einv(einv),
    .csel(csel), .start(start), .stop(stop), .abort(abort), .tmo(tmo[3:0]),
    .busy(busy_s), .done(done_s), .cte(cte_s), .ctc(ctc_s), .ovf(ovf_s), .tof(tof_s));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // lvl[n] is the input vector sampled at posedge n
  always @(posedge clk) begin
    if (cyc < MAXC) lvl[cyc+1] <= inp;
    cyc <= cyc + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk); #1;
    for (int c = 0; c < CH; c++)
      if (hp[c] != 0) inp[c] = 1'(((cyc + ph[c]) / hp[c]) % 2);
  endtask

  // Edge seen by the gate at posedge p: input sampled SYNC clocks earlier vs. one before that.
  function automatic bit edg(input int p, input int ch, input bit inv);
    if (p - SYNC - 1 < 1 || p > cyc) return 1'b0;
    return (lvl[p-SYNC][ch] ^ inv) & ~(lvl[p-SYNC-1][ch] ^ inv);
  endfunction

  // Window model: begin at t0, stop accepted at ts, close on first end edge after ts or timeout.
  function automatic void predict(input int t0, input int ts, input longint tm, input longint wmax,
                                  input int last, output int e_end, output longint e_ctc,
                                  output longint e_cte, output bit e_ovf, output bit e_tof);
    int t1, tp, hi;
    longint n;
    t1 = BIG;
    if (ts >= 0)
      for (int p = ts + 1; p <= last && t1 == BIG; p++)
        if (edg(p, int'(esel), einv)) t1 = p;
    tp    = (tm >= 2) ? t0 + int'(tm) - 1 : BIG;
    e_tof = (tp < t1);
    e_end = e_tof ? tp : t1;
    hi    = e_tof ? tp : t1 - 1;
    if (hi > last) hi = last;
    n = 0;
    for (int p = t0; p <= hi; p++) if (edg(p, int'(csel), 1'b0)) n++;
    e_cte = (n > wmax) ? wmax : n;
    e_ctc = e_tof ? tm : ((longint'(t1 - t0) > wmax) ? wmax : longint'(t1 - t0));
    e_ovf = (n > wmax) || (!e_tof && longint'(t1 - t0) > wmax);
  endfunction

  task automatic measure(input string nm, input int stop_dly, input int tmo_v);
    int t0, ts, endc, e_end;
    longint e_ctc, e_cte;
    bit e_ovf, e_tof;
    tmo = 32'(tmo_v);
    start = 1'b1; tick(); start = 1'b0;
    t0 = -1;
    for (int i = 0; i < 1000 && t0 < 0; i++) begin
      tick();
      if (edg(cyc, int'(bsel), binv)) t0 = cyc;
    end
    checks++;
    if (t0 < 0) begin
      errs++; $display("FAIL %s_begin: no begin edge in 1000 cycles", nm); return;
    end
    if (ctc !== 32'd1) begin
      errs++; $display("FAIL %s_open: ctc=%0d want 1", nm, ctc);
    end
    ts = -1; endc = -1;
    for (int i = 0; i < 3000 && endc < 0; i++) begin
      if (i == stop_dly) begin stop = 1'b1; ts = cyc + 1; end
      tick(); stop = 1'b0;
      if (done === 1'b1) endc = cyc;
    end
    checks++;
    if (endc < 0) begin
      errs++; $display("FAIL %s_done: no done in 3000 cycles", nm); return;
    end
    predict(t0, ts, longint'(tmo_v), 64'hFFFF_FFFF, cyc, e_end, e_ctc, e_cte, e_ovf, e_tof);
    if (endc !== e_end) begin errs++; $display("FAIL %s_end: cycle %0d want %0d", nm, endc, e_end); end
    checks++;
    if (ctc !== 32'(e_ctc)) begin errs++; $display("FAIL %s_ctc: %0d want %0d", nm, ctc, e_ctc); end
    checks++;
    if (cte !== 32'(e_cte)) begin errs++; $display("FAIL %s_cte: %0d want %0d", nm, cte, e_cte); end
    checks++;
    if ({ovf, tof} !== {e_ovf, e_tof}) begin
      errs++; $display("FAIL %s_flags: ovf/tof=%b%b want %b%b", nm, ovf, tof, e_ovf, e_tof);
    end
    tick();
    checks++;
    if ({done, busy} !== 2'b00) begin
      errs++; $display("FAIL %s_after: done/busy=%b%b want 00", nm, done, busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; repeat (3) tick();
    checks++;
    if ({cte, ctc} !== 64'd0) begin errs++; $display("FAIL reset_cnt: cte=%0d ctc=%0d want 0", cte, ctc); end
    checks++;
    if ({busy, done, ovf, tof} !== 4'b0) begin
      errs++; $display("FAIL reset_flags: %b want 0000", {busy, done, ovf, tof});
    end
    checks++;
    if ({busy_s, ctc_s, cte_s} !== 9'd0) begin errs++; $display("FAIL reset_small: %b want 0", {busy_s, ctc_s, cte_s}); end
    rst = 1'b0; tick();
  endtask

  task automatic test_period();
    bsel = 0; esel = 0; csel = 0; binv = 0; einv = 0;
    hp = '{50, 0, 0, 0}; ph = '{0, 0, 0, 0};
    measure("period", 249, 0);
    checks++;
    if (ctc !== 32'd300) begin errs++; $display("FAIL period_300: ctc=%0d want 300", ctc); end
    checks++;
    if (cte !== 32'd3) begin errs++; $display("FAIL period_3: cte=%0d want 3", cte); end
    for (int k = 0; k < 4; k++) begin
      for (int c = 0; c < CH; c++) begin
        hp[c] = $urandom_range(30, 3); ph[c] = $urandom_range(50, 0);
      end
      csel = 2'($urandom_range(3, 0));
      measure("period_rnd", $urandom_range(120, 0), ($urandom_range(1, 0) == 1) ? $urandom_range(200, 20) : 0);
    end
  endtask

  task automatic test_cross();
    int t0, ts, endc, e_end;
    longint e_ctc, e_cte;
    bit e_ovf, e_tof;
    bsel = 1; binv = 1; esel = 2; einv = 0; csel = 3; tmo = 0;
    hp = '{0, 0, 0, $urandom_range(6, 2)};
    inp[1] = 1'b1; inp[2] = 1'b0; repeat (SYNC + 3) tick();
    start = 1'b1; tick(); start = 1'b0;
    inp[1] = 1'b0; t0 = cyc + 1 + SYNC;
    repeat (SYNC + 3) tick();
    stop = 1'b1; ts = cyc + 1; tick(); stop = 1'b0;
    while (cyc < t0 + 36 - SYNC) tick();
    inp[2] = 1'b1;
    endc = -1;
    for (int i = 0; i < 60 && endc < 0; i++) begin tick(); if (done === 1'b1) endc = cyc; end
    checks++;
    if (endc !== t0 + 37) begin errs++; $display("FAIL cross_end: cycle %0d want %0d", endc, t0 + 37); end
    checks++;
    if (ctc !== 32'd37) begin errs++; $display("FAIL cross_ctc: %0d want 37", ctc); end
    predict(t0, ts, 0, 64'hFFFF_FFFF, cyc, e_end, e_ctc, e_cte, e_ovf, e_tof);
    checks++;
    if (cte !== 32'(e_cte)) begin errs++; $display("FAIL cross_cte: %0d want %0d", cte, e_cte); end
    inp[1] = 1'b1; inp[2] = 1'b0; tick();
  endtask

  task automatic test_timeout();
    bsel = 0; binv = 0; esel = 2; einv = 0; csel = 1;
    hp = '{$urandom_range(10, 3), 0, 0, 0}; inp[1] = 1'b0; inp[2] = 1'b0;
    measure("timeout", 5, 50);
    checks++;
    if ({tof, ctc} !== {1'b1, 32'd50}) begin errs++; $display("FAIL timeout_50: tof=%b ctc=%0d want 1/50", tof, ctc); end
  endtask

  task automatic test_saturation();
    int t0, ts, endc, e_end;
    longint e_ctc, e_cte;
    bit e_ovf, e_tof;
    bsel = 1; esel = 2; csel = 3; binv = 0; einv = 0; tmo = 0;
    hp = '{0, 0, 0, 1}; inp[1] = 1'b0; inp[2] = 1'b0; repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    inp[1] = 1'b1; t0 = cyc + 1 + SYNC;
    repeat (SYNC + 4) tick();
    stop = 1'b1; ts = cyc + 1; tick(); stop = 1'b0;
    while (cyc < t0 + 39 - SYNC) tick();
    inp[2] = 1'b1;
    endc = -1;
    for (int i = 0; i < 60 && endc < 0; i++) begin tick(); if (done_s === 1'b1) endc = cyc; end
    checks++;
    if (endc !== t0 + 40) begin errs++; $display("FAIL sat_done: cycle %0d want %0d", endc, t0 + 40); end
    checks++;
    if ({ovf_s, ctc_s} !== {1'b1, 4'd15}) begin errs++; $display("FAIL sat_ctc: ovf=%b ctc=%0d want 1/15", ovf_s, ctc_s); end
    predict(t0, ts, 0, 15, cyc, e_end, e_ctc, e_cte, e_ovf, e_tof);
    checks++;
    if (cte_s !== 4'(e_cte)) begin errs++; $display("FAIL sat_cte: %0d want %0d", cte_s, e_cte); end
    predict(t0, ts, 0, 64'hFFFF_FFFF, cyc, e_end, e_ctc, e_cte, e_ovf, e_tof);
    checks++;
    if ({ovf, ctc, cte} !== {e_ovf, 32'(e_ctc), 32'(e_cte)}) begin
      errs++; $display("FAIL sat_wide: ovf=%b ctc=%0d cte=%0d want %b/%0d/%0d", ovf, ctc, cte, e_ovf, e_ctc, e_cte);
    end
    inp[1] = 1'b0; inp[2] = 1'b0; tick();
  endtask

  task automatic test_abort();
    int ndone;
    bit hit;
    bsel = 0; esel = 0; csel = 0; binv = 0; einv = 0; tmo = 0;
    hp = '{40, 0, 0, 0};
    start = 1'b1; tick(); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin tick(); if (ctc === 32'd20) hit = 1'b1; end
    checks++;
    if (!hit) begin errs++; $display("FAIL abort_reach: ctc=%0d never reached 20", ctc); end
    abort = 1'b1; tick(); abort = 1'b0;
    checks++;
    if ({busy, ctc} !== {1'b0, 32'd20}) begin errs++; $display("FAIL abort_hold: busy=%b ctc=%0d want 0/20", busy, ctc); end
    ndone = 0;
    repeat (12) begin tick(); if (done !== 1'b0) ndone++; end
    checks++;
    if (ndone !== 0 || ctc !== 32'd20) begin errs++; $display("FAIL abort_nodone: done=%0d ctc=%0d want 0/20", ndone, ctc); end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, ctc, cte} !== {1'b1, 64'd0}) begin
      errs++; $display("FAIL abort_restart: busy=%b ctc=%0d cte=%0d want 1/0/0", busy, ctc, cte);
    end
    abort = 1'b1; tick(); abort = 1'b0;
  endtask

  task automatic test_race();
    int t0, ts, tr, t1, endc, e_end;
    longint e_ctc, e_cte;
    bit e_ovf, e_tof;
    bsel = 3; esel = 3; binv = 0; einv = 0; csel = 0; tmo = 0;
    hp = '{3, 0, 0, 0}; inp[3] = 1'b0; repeat (4) tick();
    start = 1'b1; tick(); start = 1'b0;
    inp[3] = 1'b1; t0 = cyc + 1 + SYNC; repeat (2) tick();
    inp[3] = 1'b0; repeat (4) tick();
    inp[3] = 1'b1; tr = cyc + 1 + SYNC; repeat (SYNC) tick();
    stop = 1'b1; ts = cyc + 1; tick(); stop = 1'b0;
    checks++;
    if ({busy, done} !== 2'b10 || ts !== tr) begin
      errs++; $display("FAIL race_ignore: busy/done=%b%b want 10 (ts=%0d tr=%0d)", busy, done, ts, tr);
    end
    repeat (3) tick(); inp[3] = 1'b0; repeat (6) tick();
    inp[3] = 1'b1; t1 = cyc + 1 + SYNC;
    endc = -1;
    for (int i = 0; i < 40 && endc < 0; i++) begin tick(); if (done === 1'b1) endc = cyc; end
    checks++;
    if (endc !== t1 || ctc !== 32'(t1 - t0)) begin
      errs++; $display("FAIL race_close: end=%0d ctc=%0d want %0d/%0d", endc, ctc, t1, t1 - t0);
    end
    predict(t0, ts, 0, 64'hFFFF_FFFF, cyc, e_end, e_ctc, e_cte, e_ovf, e_tof);
    checks++;
    if (cte !== 32'(e_cte)) begin errs++; $display("FAIL race_cte: %0d want %0d", cte, e_cte); end
    inp[3] = 1'b0; repeat (3) tick();
    start = 1'b1; tick(); start = 1'b0;
    inp[3] = 1'b1; repeat (SYNC + 6) tick();
    stop = 1'b1; tick(); stop = 1'b0; repeat (3) tick();
    checks++;
    if (busy !== 1'b1 || ctc === 32'd0) begin errs++; $display("FAIL rst_pre: busy=%b ctc=%0d want 1/nonzero", busy, ctc); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++;
    if ({busy, done, ovf, tof, cte, ctc} !== 68'd0) begin
      errs++; $display("FAIL rst_close: busy=%b done=%b cte=%0d ctc=%0d want all 0", busy, done, cte, ctc);
    end
  endtask

  task automatic test_back_to_back();
    bit hit;
    bsel = 0; esel = 0; csel = 0; binv = 0; einv = 0; tmo = 0;
    hp = '{4, 0, 0, 0};
    start = 1'b1; tick(); start = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin tick(); if (ctc !== 32'd0) hit = 1'b1; end
    stop = 1'b1; tick(); stop = 1'b0;
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin tick(); if (done === 1'b1) hit = 1'b1; end
    checks++;
    if (!hit) begin errs++; $display("FAIL b2b_done: no done in 100 cycles"); end
    start = 1'b1; tick(); start = 1'b0;
    checks++;
    if ({busy, done, ctc, tof} !== {2'b10, 32'd0, 1'b0}) begin
      errs++; $display("FAIL b2b_rearm: busy=%b done=%b ctc=%0d want 1/0/0", busy, done, ctc);
    end
    measure("b2b", $urandom_range(30, 0), 0);
  endtask

  initial begin
    inp = '0; bsel = '0; esel = '0; csel = '0; binv = 0; einv = 0;
    start = 0; stop = 0; abort = 0; tmo = '0; rst = 1'b1;
    hp = '{0, 0, 0, 0}; ph = '{0, 0, 0, 0};
    test_reset();
    test_period();
    test_cross();
    test_timeout();
    test_saturation();
    test_abort();
    test_race();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
